// File: rtl/fsb_watchdog.sv
// ---------------------------------------------------------------------------
// fsb_watchdog
//
// Bus-cycle watchdog for the MC68HC000 front-side bus.  Every /AS cycle is
// timed from the edge that first samples nAS low.  If neither /DTACK nor /VPA
// terminates the cycle within the selected limit, the watchdog ends it:
// ordinary cycles get a bus-error request, and interrupt-acknowledge cycles
// can optionally get an autovector request instead.  A saturating count of
// timeout events is kept for diagnostics.
//
// Optional feature macro:
//   WATCHDOG_SPURVPA_EN  - when defined, an IACK cycle that times out raises
//                          SpurVPA instead of BERR.  When undefined, SpurVPA
//                          is tied low and IACK timeouts raise BERR.
//
// Parameters:
//   CNT_W       timeout counter width (must be able to hold 511)
//
// Ports:
//   FCLK        in   1  FSB clock, all state changes on the rising edge
//   nRES        in   1  asynchronous active-low reset
//   nAS         in   1  FSB address strobe, active-low
//   nDTACK      in   1  FSB /DTACK as driven to the CPU, active-low
//   nVPA        in   1  FSB /VPA as driven to the CPU, active-low
//   IACKCS      in   1  current cycle is an interrupt acknowledge
//   IOACT       in   1  I/O bus master transaction active, freezes the timer
//   TimeoutSel  in   2  limit select: 0=64, 1=128, 2=256, 3=512 FCLK cycles
//   Clr         in   1  synchronous clear of TOCount
//   BERR        out  1  bus-error request (registered)
//   SpurVPA     out  1  autovector request for an unanswered IACK (registered)
//   TOCount     out  8  saturating count of timeout events
// ---------------------------------------------------------------------------
module fsb_watchdog #(
    parameter int CNT_W = 10
) (
    input  logic       FCLK,
    input  logic       nRES,
    input  logic       nAS,
    input  logic       nDTACK,
    input  logic       nVPA,
    input  logic       IACKCS,
    input  logic       IOACT,
    input  logic [1:0] TimeoutSel,
    input  logic       Clr,
    output logic       BERR,
    output logic       SpurVPA,
    output logic [7:0] TOCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] r_limitM1;
    logic [CNT_W-1:0] w_limitM1Next;
    logic [CNT_W-1:0] w_selLimitM1;
    logic             w_timeout;
    logic             w_faultNext;
    logic             w_berrNext;
    logic             r_berr;
    logic [7:0]       r_toCount;

    // The limit is stored as L-1 so the terminal compare is a plain equality
    // against the running count.
    always_comb begin
        w_selLimitM1 = CNT_W'(63);
        case (TimeoutSel)
            2'd0:    w_selLimitM1 = CNT_W'(63);
            2'd1:    w_selLimitM1 = CNT_W'(127);
            2'd2:    w_selLimitM1 = CNT_W'(255);
            default: w_selLimitM1 = CNT_W'(511);
        endcase
    end

    // Next-state logic.  In COUNT the checks are ordered so that /AS
    // negation beats an acknowledge, an acknowledge beats the IOACT freeze,
    // and the freeze beats the timeout.  This lets a late acknowledge or a
    // cycle that ends on the limit edge finish cleanly without a fault.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_limitM1Next = r_limitM1;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!nAS) begin
                    w_stateNext   = COUNT;
                    w_cntNext     = '0;
                    w_limitM1Next = w_selLimitM1;
                end
            end
            COUNT: begin
                if (nAS) begin
                    w_stateNext = IDLE;
                end else if (!nDTACK || !nVPA) begin
                    w_stateNext = DONE;
                end else if (IOACT) begin
                    w_cntNext = r_cnt;
                end else if (r_cnt == r_limitM1) begin
                    w_stateNext = FAULT;
                    w_timeout   = 1'b1;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            DONE: begin
                if (nAS) begin
                    w_stateNext = IDLE;
                end
            end
            FAULT: begin
                if (nAS) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, counter and latched limit.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_limitM1 <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_limitM1 <= w_limitM1Next;
        end
    end

    assign w_faultNext = (w_stateNext == FAULT);

`ifdef WATCHDOG_SPURVPA_EN
    logic r_iack;
    logic w_iackNext;
    logic w_spurNext;
    logic r_spur;

    // IACKCS is captured on the edge that enters FAULT; the response type
    // stays fixed for the rest of the faulted cycle.
    assign w_iackNext = w_timeout ? IACKCS : r_iack;
    assign w_berrNext = w_faultNext & ~w_iackNext;
    assign w_spurNext = w_faultNext &  w_iackNext;

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_iack <= 1'b0;
            r_spur <= 1'b0;
        end else begin
            r_iack <= w_iackNext;
            r_spur <= w_spurNext;
        end
    end

    assign SpurVPA = r_spur;
`else
    logic w_unusedIack;

    // Without the autovector option every timeout is reported as a bus
    // error, so the IACK qualifier plays no part.
    assign w_unusedIack = IACKCS;
    assign w_berrNext   = w_faultNext;
    assign SpurVPA      = 1'b0;
`endif

    // Bus-error request, registered from the next state so the output has
    // no combinational path from the bus inputs.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_berr <= 1'b0;
        end else begin
            r_berr <= w_berrNext;
        end
    end

    // Diagnostic fault counter: bumps on the same edge the fault is raised,
    // saturates at 255, and a clear on that edge takes precedence.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_toCount <= 8'd0;
        end else if (Clr) begin
            r_toCount <= 8'd0;
        end else if (w_timeout && (r_toCount != 8'hFF)) begin
            r_toCount <= r_toCount + 8'd1;
        end
    end

    assign BERR    = r_berr;
    assign TOCount = r_toCount;

endmodule

// File: tb/tb_fsb_watchdog.sv
// ---------------------------------------------------------------------------
// tb_fsb_watchdog
//
// Directed bench for fsb_watchdog.  Stimulus pushes the expected fault event
// (edge index, BERR, SpurVPA, TOCount) into a queue; a monitor pops and
// compares each time the DUT raises BERR or SpurVPA.  Edge indices count
// rising FCLK edges; a cycle's edge 0 is the edge that first samples nAS=0.
// ---------------------------------------------------------------------------
module tb_fsb_watchdog;

    logic       FCLK = 1'b0;
    logic       nRES = 1'b0;
    logic       nAS = 1'b1;
    logic       nDTACK = 1'b1;
    logic       nVPA = 1'b1;
    logic       IACKCS = 1'b0;
    logic       IOACT = 1'b0;
    logic [1:0] TimeoutSel = 2'd0;
    logic       Clr = 1'b0;
    logic       BERR;
    logic       SpurVPA;
    logic [7:0] TOCount;

`ifdef WATCHDOG_SPURVPA_EN
    localparam bit SPUR_EN = 1'b1;
`else
    localparam bit SPUR_EN = 1'b0;
`endif

    typedef struct {
        int edgeIdx;
        bit berr;
        bit spur;
        int toc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   tocModel = 0;
    int   edgeCnt = 0;
    int   limits [4] = '{64, 128, 256, 512};

    fsb_watchdog #(.CNT_W(10)) dut (
        .FCLK       (FCLK),
        .nRES       (nRES),
        .nAS        (nAS),
        .nDTACK     (nDTACK),
        .nVPA       (nVPA),
        .IACKCS     (IACKCS),
        .IOACT      (IOACT),
        .TimeoutSel (TimeoutSel),
        .Clr        (Clr),
        .BERR       (BERR),
        .SpurVPA    (SpurVPA),
        .TOCount    (TOCount)
    );

    // Free-running clock and rising-edge index.
    always #5 FCLK = ~FCLK;

    always @(posedge FCLK) edgeCnt <= edgeCnt + 1;

    // Safety net so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] aborted");
    end

    // Monitor: every rising edge of BERR|SpurVPA must match the oldest
    // queued expectation, including the edge on which it appeared.
    initial begin
        bit   prevFlag;
        bit   flag;
        exp_t e;
        prevFlag = 1'b0;
        forever begin
            @(negedge FCLK);
            flag = BERR || SpurVPA;
            if (flag && !prevFlag) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_fault: edge=%0d BERR=%b SpurVPA=%b TOCount=%0d, required no fault",
                             edgeCnt, BERR, SpurVPA, TOCount);
                end else begin
                    e = sb.pop_front();
                    if (edgeCnt != e.edgeIdx || BERR !== e.berr || SpurVPA !== e.spur || TOCount !== 8'(e.toc)) begin
                        errors++;
                        $display("[TB] FAIL fault_event: edge=%0d BERR=%b SpurVPA=%b TOCount=%0d, required edge=%0d BERR=%b SpurVPA=%b TOCount=%0d",
                                 edgeCnt, BERR, SpurVPA, TOCount, e.edgeIdx, e.berr, e.spur, e.toc);
                    end
                end
            end
            prevFlag = flag;
        end
    end

    // Queue the fault expected on the given edge and advance the count model.
    task automatic pushFault(input int edgeIdx, input bit iack, input bit clrSameEdge);
        exp_t e;
        if (clrSameEdge) tocModel = 0;
        else if (tocModel < 255) tocModel = tocModel + 1;
        e.edgeIdx = edgeIdx;
        e.berr    = !(iack && SPUR_EN);
        e.spur    = iack && SPUR_EN;
        e.toc     = tocModel;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input bit eB, input bit eS, input int eT);
        checks++;
        if (BERR !== eB || SpurVPA !== eS || TOCount !== 8'(eT)) begin
            errors++;
            $display("[TB] FAIL %s: BERR=%b SpurVPA=%b TOCount=%0d, required BERR=%b SpurVPA=%b TOCount=%0d",
                     name, BERR, SpurVPA, TOCount, eB, eS, eT);
        end
    endtask

    task automatic waitEdge(input int target);
        while (edgeCnt < target) @(negedge FCLK);
    endtask

    // Start a bus cycle; must be called right after a falling edge.
    task automatic applyStimulus(input logic [1:0] sel, input bit iack, output int startEdge);
        TimeoutSel = sel;
        IACKCS     = iack;
        nAS        = 1'b0;
        startEdge  = edgeCnt + 1;
    endtask

    task automatic releaseAs();
        nAS    = 1'b1;
        nDTACK = 1'b1;
        nVPA   = 1'b1;
        IOACT  = 1'b0;
        IACKCS = 1'b0;
        @(negedge FCLK);
    endtask

    // One unanswered cycle that runs to its limit and is then released.
    task automatic runTimeout(input logic [1:0] sel, input bit iack, input string name, input bit detailed);
        int start;
        int lim;
        bit eB;
        bit eS;
        lim = limits[sel];
        applyStimulus(sel, iack, start);
        waitEdge(start + lim - 1);
        if (detailed) checkOutput({name, "_before_limit"}, 1'b0, 1'b0, tocModel);
        pushFault(start + lim, iack, 1'b0);
        waitEdge(start + lim);
        eB = !(iack && SPUR_EN);
        eS = iack && SPUR_EN;
        if (detailed) begin
            checkOutput({name, "_at_limit"}, eB, eS, tocModel);
            repeat (3) @(negedge FCLK);
            checkOutput({name, "_held"}, eB, eS, tocModel);
        end
        releaseAs();
        if (detailed) checkOutput({name, "_dropped"}, 1'b0, 1'b0, tocModel);
    endtask

    initial begin
        int start;

        // Reset held while nAS toggles: outputs must stay quiet.
        for (int i = 0; i < 6; i++) begin
            @(negedge FCLK);
            nAS = i[0];
            IACKCS = i[1];
            checkOutput("reset_hold", 1'b0, 1'b0, 0);
        end
        @(negedge FCLK);
        nAS  = 1'b1;
        nRES = 1'b1;
        @(negedge FCLK);
        checkOutput("after_reset", 1'b0, 1'b0, 0);

        // Shortest limit: fault on edge 64, TOCount=1.
        runTimeout(2'd0, 1'b0, "min_limit", 1'b1);

        // /DTACK sampled exactly on edge 128 still terminates the cycle.
        applyStimulus(2'd1, 1'b0, start);
        waitEdge(start + 127);
        nDTACK = 1'b0;
        @(negedge FCLK);
        nDTACK = 1'b1;
        repeat (3) @(negedge FCLK);
        checkOutput("dtack_at_limit", 1'b0, 1'b0, 1);
        releaseAs();

        // /VPA on edge 64 likewise.
        applyStimulus(2'd0, 1'b0, start);
        waitEdge(start + 63);
        nVPA = 1'b0;
        @(negedge FCLK);
        repeat (2) @(negedge FCLK);
        checkOutput("vpa_at_limit", 1'b0, 1'b0, 1);
        releaseAs();

        // /AS negated on the timeout edge wins over the timeout.
        applyStimulus(2'd0, 1'b0, start);
        waitEdge(start + 63);
        nAS = 1'b1;
        @(negedge FCLK);
        repeat (2) @(negedge FCLK);
        checkOutput("as_negation_at_limit", 1'b0, 1'b0, 1);

        // IOACT on edges 10..29 delays the fault to edge 84; a TimeoutSel
        // change mid-cycle has no effect.
        applyStimulus(2'd0, 1'b0, start);
        waitEdge(start + 9);
        IOACT      = 1'b1;
        TimeoutSel = 2'd3;
        waitEdge(start + 29);
        IOACT = 1'b0;
        waitEdge(start + 83);
        checkOutput("freeze_edge83", 1'b0, 1'b0, 1);
        pushFault(start + 84, 1'b0, 1'b0);
        waitEdge(start + 84);
        checkOutput("freeze_edge84", 1'b1, 1'b0, 2);
        releaseAs();
        checkOutput("freeze_dropped", 1'b0, 1'b0, 2);

        // IACK timeout at limit 256.
        runTimeout(2'd2, 1'b1, "iack", 1'b1);

        // Longest limit: fault on edge 512.
        runTimeout(2'd3, 1'b0, "max_limit", 1'b1);

        // Back-to-back timeouts to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            runTimeout(2'd0, 1'b0, "sat", 1'b0);
        end
        checkOutput("saturated", 1'b0, 1'b0, 255);

        // Clr on the same edge as a timeout: the clear wins.
        applyStimulus(2'd0, 1'b0, start);
        waitEdge(start + 63);
        Clr = 1'b1;
        pushFault(start + 64, 1'b0, 1'b1);
        @(negedge FCLK);
        Clr = 1'b0;
        checkOutput("clr_wins", 1'b1, 1'b0, 0);
        releaseAs();

        // Asynchronous reset in the middle of FAULT.
        applyStimulus(2'd0, 1'b0, start);
        waitEdge(start + 63);
        pushFault(start + 64, 1'b0, 1'b0);
        waitEdge(start + 64);
        checkOutput("pre_reset_fault", 1'b1, 1'b0, 1);
        #2;
        nRES = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 0);
        tocModel = 0;
        @(negedge FCLK);
        nAS = 1'b1;
        @(negedge FCLK);
        nRES = 1'b1;
        repeat (2) @(negedge FCLK);
        checkOutput("post_reset", 1'b0, 1'b0, 0);

        // Every queued fault must have been observed.
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d, required pending=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
